// File: rtl/wf_inflight_tracker_pkg.sv
// Shared issue-stage definitions for the in-flight tracker.
// Holds wavefront geometry, counter sizing, error-code encodings and the
// wavefront-ID to one-hot enable decoder used once per input port.
package wf_inflight_tracker_pkg;

    localparam int NUM_WF       = 40;
    localparam int WFID_W       = 6;
    localparam int CNT_W        = 3;
    localparam int MAX_INFLIGHT = 4;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_UNF  = 2'b10;
    localparam logic [1:0] ERR_WFID = 2'b11;

    // Out-of-range IDs decode to all zeros, so they never touch a counter.
    function automatic logic [NUM_WF-1:0] wfid_decode(input logic              valid,
                                                      input logic [WFID_W-1:0] wfid);
        logic [NUM_WF-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_WF; i++) begin
            if (valid && (wfid == WFID_W'(i))) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/wf_inflight_tracker_cnt_cell.sv
// inflight_cnt_cell: outstanding-instruction counter for one wavefront.
// Ports:
//   i_clk, i_rst  - clock, synchronous active-high reset
//   i_clear       - wavefront deallocated; count forced to 0, no error
//   i_inc         - one instruction issued this cycle
//   i_dec[2:0]    - retire strobes from SALU, VALU and LSU
//   o_full        - count == MAX_INFLIGHT (decoded from register)
//   o_empty       - count == 0 (decoded from register)
//   o_ovf, o_unf  - this cycle's update would overflow / underflow
module inflight_cnt_cell
    import wf_inflight_tracker_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clear,
    input  logic       i_inc,
    input  logic [2:0] i_dec,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_ovf,
    output logic       o_unf
);

    logic [CNT_W-1:0] r_count;
    logic [1:0]       w_dec_cnt;
    logic [CNT_W+1:0] w_next;
    logic             w_neg;
    logic             w_over;

    assign w_dec_cnt = {1'b0, i_dec[0]} + {1'b0, i_dec[1]} + {1'b0, i_dec[2]};

    // Two extra bits: the top one acts as the sign of the two's-complement result.
    assign w_next = {2'b00, r_count} + {{(CNT_W+1){1'b0}}, i_inc}
                  - {{CNT_W{1'b0}}, w_dec_cnt};
    assign w_neg  = w_next[CNT_W+1];
    assign w_over = !w_neg && (w_next > (CNT_W+2)'(MAX_INFLIGHT));

    assign o_ovf = !i_clear && w_over;
    assign o_unf = !i_clear && w_neg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear || w_neg) begin
            r_count <= '0;
        end else if (!w_over) begin
            r_count <= w_next[CNT_W-1:0];
        end
    end

    assign o_full  = (r_count == CNT_W'(MAX_INFLIGHT));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/wf_inflight_tracker.sv
// wf_inflight_tracker: per-wavefront outstanding-instruction tracker.
// Ports:
//   i_clk, i_rst                          - clock, synchronous active-high reset
//   i_issued_valid / i_issued_wfid        - arbiter issue
//   i_salu_done / i_salu_done_wfid        - SALU retire
//   i_valu_done / i_valu_done_wfid        - SIMD/SIMF retire
//   i_lsu_done / i_lsu_done_wfid          - LSU retire
//   i_wf_clear_valid / i_wf_clear_wfid    - wavefront deallocation
//   o_inflight_full / o_inflight_empty    - per-wavefront masks
//   o_err_valid, o_err_code, o_err_wfid   - sticky first-error capture
module wf_inflight_tracker
    import wf_inflight_tracker_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_issued_valid,
    input  logic [WFID_W-1:0] i_issued_wfid,
    input  logic              i_salu_done,
    input  logic [WFID_W-1:0] i_salu_done_wfid,
    input  logic              i_valu_done,
    input  logic [WFID_W-1:0] i_valu_done_wfid,
    input  logic              i_lsu_done,
    input  logic [WFID_W-1:0] i_lsu_done_wfid,
    input  logic              i_wf_clear_valid,
    input  logic [WFID_W-1:0] i_wf_clear_wfid,
    output logic [NUM_WF-1:0] o_inflight_full,
    output logic [NUM_WF-1:0] o_inflight_empty,
    output logic              o_err_valid,
    output logic [1:0]        o_err_code,
    output logic [WFID_W-1:0] o_err_wfid
);

    logic [NUM_WF-1:0] w_inc, w_dec_salu, w_dec_valu, w_dec_lsu, w_clear;
    logic [NUM_WF-1:0] w_ovf, w_unf;

    assign w_inc      = wfid_decode(i_issued_valid,   i_issued_wfid);
    assign w_dec_salu = wfid_decode(i_salu_done,      i_salu_done_wfid);
    assign w_dec_valu = wfid_decode(i_valu_done,      i_valu_done_wfid);
    assign w_dec_lsu  = wfid_decode(i_lsu_done,       i_lsu_done_wfid);
    assign w_clear    = wfid_decode(i_wf_clear_valid, i_wf_clear_wfid);

    for (genvar g = 0; g < NUM_WF; g++) begin : g_cell
        inflight_cnt_cell u_cell (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_clear (w_clear[g]),
            .i_inc   (w_inc[g]),
            .i_dec   ({w_dec_lsu[g], w_dec_valu[g], w_dec_salu[g]}),
            .o_full  (o_inflight_full[g]),
            .o_empty (o_inflight_empty[g]),
            .o_ovf   (w_ovf[g]),
            .o_unf   (w_unf[g])
        );
    end

    logic [4:0]        w_port_vld;
    logic [WFID_W-1:0] w_port_id [5];
    logic              w_bad_hit;
    logic [WFID_W-1:0] w_bad_wfid;
    logic              w_cell_hit;
    logic [1:0]        w_cell_code;
    logic [WFID_W-1:0] w_cell_wfid;
    logic              w_err_hit;
    logic [1:0]        w_err_code;
    logic [WFID_W-1:0] w_err_wfid;

    always_comb begin
        w_port_vld   = {i_wf_clear_valid, i_lsu_done, i_valu_done, i_salu_done, i_issued_valid};
        w_port_id[0] = i_issued_wfid;
        w_port_id[1] = i_salu_done_wfid;
        w_port_id[2] = i_valu_done_wfid;
        w_port_id[3] = i_lsu_done_wfid;
        w_port_id[4] = i_wf_clear_wfid;

        // Bad IDs are all >= NUM_WF, so they lose to any in-range error.
        w_bad_hit  = 1'b0;
        w_bad_wfid = '0;
        for (int p = 0; p < 5; p++) begin
            if (w_port_vld[p] && (w_port_id[p] >= WFID_W'(NUM_WF)) &&
                (!w_bad_hit || (w_port_id[p] < w_bad_wfid))) begin
                w_bad_hit  = 1'b1;
                w_bad_wfid = w_port_id[p];
            end
        end

        // Descending scan so the lowest-numbered erroring wavefront is left last.
        w_cell_hit  = 1'b0;
        w_cell_code = ERR_NONE;
        w_cell_wfid = '0;
        for (int i = NUM_WF - 1; i >= 0; i--) begin
            if (w_unf[i] || w_ovf[i]) begin
                w_cell_hit  = 1'b1;
                w_cell_code = w_unf[i] ? ERR_UNF : ERR_OVF;
                w_cell_wfid = WFID_W'(i);
            end
        end

        w_err_hit  = w_cell_hit || w_bad_hit;
        w_err_code = w_cell_hit ? w_cell_code : ERR_WFID;
        w_err_wfid = w_cell_hit ? w_cell_wfid : w_bad_wfid;
    end

    logic              r_err_valid;
    logic [1:0]        r_err_code;
    logic [WFID_W-1:0] r_err_wfid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err_valid <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_err_wfid  <= '0;
        end else if (!r_err_valid && w_err_hit) begin
            r_err_valid <= 1'b1;
            r_err_code  <= w_err_code;
            r_err_wfid  <= w_err_wfid;
        end
    end

    assign o_err_valid = r_err_valid;
    assign o_err_code  = r_err_code;
    assign o_err_wfid  = r_err_wfid;

endmodule

// File: tb/tb_wf_inflight_tracker.sv
module tb_wf_inflight_tracker;

    localparam int NW = 40;
    localparam logic [NW-1:0] ALL1 = '1;

    logic          clk;
    logic          rst;
    logic          issued_valid;
    logic [5:0]    issued_wfid;
    logic          salu_done;
    logic [5:0]    salu_wfid;
    logic          valu_done;
    logic [5:0]    valu_wfid;
    logic          lsu_done;
    logic [5:0]    lsu_wfid;
    logic          clr_valid;
    logic [5:0]    clr_wfid;
    logic [NW-1:0] full;
    logic [NW-1:0] empty;
    logic          err_valid;
    logic [1:0]    err_code;
    logic [5:0]    err_wfid;

    int total = 0;
    int bad   = 0;

    wf_inflight_tracker dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_issued_valid   (issued_valid),
        .i_issued_wfid    (issued_wfid),
        .i_salu_done      (salu_done),
        .i_salu_done_wfid (salu_wfid),
        .i_valu_done      (valu_done),
        .i_valu_done_wfid (valu_wfid),
        .i_lsu_done       (lsu_done),
        .i_lsu_done_wfid  (lsu_wfid),
        .i_wf_clear_valid (clr_valid),
        .i_wf_clear_wfid  (clr_wfid),
        .o_inflight_full  (full),
        .o_inflight_empty (empty),
        .o_err_valid      (err_valid),
        .o_err_code       (err_code),
        .o_err_wfid       (err_wfid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clr_in();
        issued_valid = 1'b0; issued_wfid = '0;
        salu_done    = 1'b0; salu_wfid   = '0;
        valu_done    = 1'b0; valu_wfid   = '0;
        lsu_done     = 1'b0; lsu_wfid    = '0;
        clr_valid    = 1'b0; clr_wfid    = '0;
    endtask

    // One edge, then sample point 1 ns later with inputs returned to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        clr_in();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [5:0] id, input int n);
        for (int k = 0; k < n; k++) begin
            issued_valid = 1'b1; issued_wfid = id;
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        total++; if (empty !== ALL1) begin bad++; $display("FAIL reset_empty got=%h exp=%h", empty, ALL1); end
        total++; if (full !== '0) begin bad++; $display("FAIL reset_full got=%h exp=0", full); end
        total++; if (err_valid !== 1'b0) begin bad++; $display("FAIL reset_err_valid got=%b exp=0", err_valid); end
        total++; if (err_code !== 2'b00) begin bad++; $display("FAIL reset_err_code got=%b exp=00", err_code); end
        total++; if (err_wfid !== 6'd0) begin bad++; $display("FAIL reset_err_wfid got=%0d exp=0", err_wfid); end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        issue(6'd7, 3);
        total++; if (full[7] !== 1'b0) begin bad++; $display("FAIL fill3_full7 got=%b exp=0", full[7]); end
        total++; if (empty[7] !== 1'b0) begin bad++; $display("FAIL fill3_empty7 got=%b exp=0", empty[7]); end
        issue(6'd7, 1);
        total++; if (full[7] !== 1'b1) begin bad++; $display("FAIL fill4_full7 got=%b exp=1", full[7]); end
        total++; if (err_valid !== 1'b0) begin bad++; $display("FAIL fill4_err_valid got=%b exp=0", err_valid); end
        issue(6'd7, 1);
        total++; if (err_valid !== 1'b1) begin bad++; $display("FAIL ovf_err_valid got=%b exp=1", err_valid); end
        total++; if (err_code !== 2'b01) begin bad++; $display("FAIL ovf_err_code got=%b exp=01", err_code); end
        total++; if (err_wfid !== 6'd7) begin bad++; $display("FAIL ovf_err_wfid got=%0d exp=7", err_wfid); end
        total++; if (full[7] !== 1'b1) begin bad++; $display("FAIL ovf_hold_full7 got=%b exp=1", full[7]); end
        // Held at 4: one retire must drop it below full.
        lsu_done = 1'b1; lsu_wfid = 6'd7;
        tick();
        total++; if (full[7] !== 1'b0) begin bad++; $display("FAIL ovf_retire_full7 got=%b exp=0", full[7]); end
        total++; if (empty[7] !== 1'b0) begin bad++; $display("FAIL ovf_retire_empty7 got=%b exp=0", empty[7]); end
    endtask

    task automatic test_net_full();
        do_reset();
        issue(6'd20, 4);
        issued_valid = 1'b1; issued_wfid = 6'd20;
        salu_done    = 1'b1; salu_wfid   = 6'd20;
        tick();
        total++; if (full[20] !== 1'b1) begin bad++; $display("FAIL netfull_full20 got=%b exp=1", full[20]); end
        total++; if (err_valid !== 1'b0) begin bad++; $display("FAIL netfull_err_valid got=%b exp=0", err_valid); end
    endtask

    task automatic test_net_mixed();
        do_reset();
        issue(6'd3, 3);
        issued_valid = 1'b1; issued_wfid = 6'd3;
        salu_done    = 1'b1; salu_wfid   = 6'd3;
        lsu_done     = 1'b1; lsu_wfid    = 6'd3;
        tick();
        total++; if (full[3] !== 1'b0) begin bad++; $display("FAIL net3_full got=%b exp=0", full[3]); end
        total++; if (empty[3] !== 1'b0) begin bad++; $display("FAIL net3_empty got=%b exp=0", empty[3]); end
        valu_done = 1'b1; valu_wfid = 6'd3;
        tick();
        total++; if (empty[3] !== 1'b0) begin bad++; $display("FAIL net3_cnt1_empty got=%b exp=0", empty[3]); end
        valu_done = 1'b1; valu_wfid = 6'd3;
        tick();
        total++; if (empty[3] !== 1'b1) begin bad++; $display("FAIL net3_cnt0_empty got=%b exp=1", empty[3]); end
        total++; if (err_valid !== 1'b0) begin bad++; $display("FAIL net3_err_valid got=%b exp=0", err_valid); end
    endtask

    task automatic test_clear();
        do_reset();
        issue(6'd12, 2);
        total++; if (empty[12] !== 1'b0) begin bad++; $display("FAIL clr_pre_empty12 got=%b exp=0", empty[12]); end
        clr_valid    = 1'b1; clr_wfid    = 6'd12;
        issued_valid = 1'b1; issued_wfid = 6'd12;
        tick();
        total++; if (empty[12] !== 1'b1) begin bad++; $display("FAIL clr_empty12 got=%b exp=1", empty[12]); end
        // Clear also suppresses a same-cycle underflow.
        clr_valid = 1'b1; clr_wfid  = 6'd9;
        valu_done = 1'b1; valu_wfid = 6'd9;
        tick();
        total++; if (err_valid !== 1'b0) begin bad++; $display("FAIL clr_err_valid got=%b exp=0", err_valid); end
        total++; if (empty !== ALL1) begin bad++; $display("FAIL clr_all_empty got=%h exp=%h", empty, ALL1); end
    endtask

    task automatic test_underflow();
        do_reset();
        valu_done = 1'b1; valu_wfid = 6'd5;
        tick();
        total++; if (err_valid !== 1'b1) begin bad++; $display("FAIL unf_err_valid got=%b exp=1", err_valid); end
        total++; if (err_code !== 2'b10) begin bad++; $display("FAIL unf_err_code got=%b exp=10", err_code); end
        total++; if (err_wfid !== 6'd5) begin bad++; $display("FAIL unf_err_wfid got=%0d exp=5", err_wfid); end
        total++; if (empty[5] !== 1'b1) begin bad++; $display("FAIL unf_empty5 got=%b exp=1", empty[5]); end
        salu_done = 1'b1; salu_wfid = 6'd1;
        tick();
        total++; if (err_code !== 2'b10) begin bad++; $display("FAIL sticky_err_code got=%b exp=10", err_code); end
        total++; if (err_wfid !== 6'd5) begin bad++; $display("FAIL sticky_err_wfid got=%0d exp=5", err_wfid); end
    endtask

    task automatic test_multi_err();
        do_reset();
        issue(6'd2, 4);
        issued_valid = 1'b1; issued_wfid = 6'd2;
        valu_done    = 1'b1; valu_wfid   = 6'd8;
        tick();
        total++; if (err_code !== 2'b01) begin bad++; $display("FAIL multi_err_code got=%b exp=01", err_code); end
        total++; if (err_wfid !== 6'd2) begin bad++; $display("FAIL multi_err_wfid got=%0d exp=2", err_wfid); end
    endtask

    task automatic test_bad_wfid();
        logic [NW-1:0] exp_empty;
        do_reset();
        issue(6'd0, 1);
        issue(6'd45, 1);
        exp_empty = ALL1;
        exp_empty[0] = 1'b0;
        total++; if (empty !== exp_empty) begin bad++; $display("FAIL bad_empty got=%h exp=%h", empty, exp_empty); end
        total++; if (full !== '0) begin bad++; $display("FAIL bad_full got=%h exp=0", full); end
        total++; if (err_code !== 2'b11) begin bad++; $display("FAIL bad_err_code got=%b exp=11", err_code); end
        total++; if (err_wfid !== 6'd45) begin bad++; $display("FAIL bad_err_wfid got=%0d exp=45", err_wfid); end
        // Issue presented during reset must be discarded.
        rst = 1'b1;
        issued_valid = 1'b1; issued_wfid = 6'd3;
        tick();
        rst = 1'b0;
        total++; if (empty !== ALL1) begin bad++; $display("FAIL rst_empty got=%h exp=%h", empty, ALL1); end
        total++; if (full !== '0) begin bad++; $display("FAIL rst_full got=%h exp=0", full); end
        total++; if (err_valid !== 1'b0) begin bad++; $display("FAIL rst_err_valid got=%b exp=0", err_valid); end
        total++; if (err_code !== 2'b00) begin bad++; $display("FAIL rst_err_code got=%b exp=00", err_code); end
        total++; if (err_wfid !== 6'd0) begin bad++; $display("FAIL rst_err_wfid got=%0d exp=0", err_wfid); end
    endtask

    initial begin
        rst = 1'b1;
        clr_in();
        test_reset();
        test_fill_overflow();
        test_net_full();
        test_net_mixed();
        test_clear();
        test_underflow();
        test_multi_err();
        test_bad_wfid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
